// File: rtl/axil_slave_to_fifo.sv
// Purpose : AXI4-Lite slave; each write becomes a {data, addr} word pair pushed into a 32-bit command FIFO.
// Latency : AW+W handshake in cycle N -> data push N+1 -> address push N+2 -> bvalid N+3 (FIFO not full).
// Backpres: fifo_full stalls the pair between words; AW/W are not accepted again until the B handshake.
// Ports   : aclk/aresetn clock and async active-low reset; s_axi_aw*/w*/b* write channel; s_axi_ar*/r*
//           status read channel (rdata = {pair_cnt, 13'b0, win_err_sticky, busy, fifo_full});
//           fifo_din/fifo_wr_en/fifo_full push side of the command FIFO.
// Option  : define AXIL_FIFO_WIN_CHECK_EN to reject writes outside WIN_BASE/WIN_MASK with SLVERR.
module axil_slave_to_fifo #(
    parameter int          PAIR_CNT_W = 16,
    parameter logic [31:0] WIN_BASE   = 32'h1000_0000,
    parameter logic [31:0] WIN_MASK   = 32'hF000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, PUSH_DATA, PUSH_ADDR, RESP} state_t;

    state_t                state;
    logic                  aw_lat;
    logic                  w_lat;
    logic [31:0]           awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [PAIR_CNT_W-1:0] pair_cnt;
    logic                  win_err;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_have;
    logic                  w_have;
    logic [3:0]            strb_sel;
    logic                  win_bad;

    // A channel counts as present if it handshakes this cycle or was latched earlier,
    // so the decision is made in the handshake cycle and the data push lands in N+1.
    assign aw_hs    = s_axi_awvalid & s_axi_awready;
    assign w_hs     = s_axi_wvalid & s_axi_wready;
    assign aw_have  = aw_lat | aw_hs;
    assign w_have   = w_lat | w_hs;
    assign strb_sel = w_hs ? s_axi_wstrb : wstrb_q;

`ifdef AXIL_FIFO_WIN_CHECK_EN
    logic [31:0] addr_sel;
    assign addr_sel = aw_hs ? s_axi_awaddr : awaddr_q;
    assign win_bad  = (addr_sel & WIN_MASK) != (WIN_BASE & WIN_MASK);
`else
    logic unused_ok;
    assign win_bad   = 1'b0;
    assign win_err   = 1'b0;
    assign unused_ok = ^{WIN_BASE, WIN_MASK};
`endif

    logic unused_araddr;
    assign unused_araddr = ^s_axi_araddr;

    // Push strobe is gated combinationally by fifo_full so a word is offered only when it can land.
    assign fifo_wr_en  = ((state == PUSH_DATA) || (state == PUSH_ADDR)) && !fifo_full;
    assign fifo_din    = (state == PUSH_DATA) ? wdata_q :
                         (state == PUSH_ADDR) ? awaddr_q : 32'h0;
    assign s_axi_rresp = RESP_OKAY;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            aw_lat        <= 1'b0;
            w_lat         <= 1'b0;
            awaddr_q      <= 32'h0;
            wdata_q       <= 32'h0;
            wstrb_q       <= 4'h0;
            pair_cnt      <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
`ifdef AXIL_FIFO_WIN_CHECK_EN
            win_err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        awaddr_q      <= s_axi_awaddr;
                        aw_lat        <= 1'b1;
                        s_axi_awready <= 1'b0;
                    end else if (!aw_lat) begin
                        s_axi_awready <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q      <= s_axi_wdata;
                        wstrb_q      <= s_axi_wstrb;
                        w_lat        <= 1'b1;
                        s_axi_wready <= 1'b0;
                    end else if (!w_lat) begin
                        s_axi_wready <= 1'b1;
                    end
                    if (aw_have && w_have) begin
                        if ((strb_sel != 4'hF) || win_bad) begin
                            state        <= RESP;
                            s_axi_bresp  <= RESP_SLVERR;
                            s_axi_bvalid <= 1'b1;
                        end else begin
                            state <= PUSH_DATA;
                        end
`ifdef AXIL_FIFO_WIN_CHECK_EN
                        if (win_bad) begin
                            win_err <= 1'b1;
                        end
`endif
                    end
                end
                PUSH_DATA: begin
                    if (!fifo_full) begin
                        state <= PUSH_ADDR;
                    end
                end
                PUSH_ADDR: begin
                    if (!fifo_full) begin
                        pair_cnt     <= pair_cnt + PAIR_CNT_W'(1);
                        s_axi_bresp  <= RESP_OKAY;
                        s_axi_bvalid <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        aw_lat        <= 1'b0;
                        w_lat         <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status read path runs independently of the write FSM; the snapshot is taken at the
    // AR handshake, so a coinciding final push is reported with the pre-increment count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'h0;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= {16'(pair_cnt), 13'b0, win_err, (state != IDLE), fifo_full};
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_arready <= 1'b1;
        end else if (!s_axi_rvalid) begin
            s_axi_arready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axil_slave_to_fifo.sv
// Purpose : directed self-checking bench for axil_slave_to_fifo.
// Latency : checks the N+1 / N+2 / N+3 push and response timing against hand-computed cycles.
// Backpres: drives fifo_full, delayed bready and delayed rready to exercise stalls.
module tb_axil_slave_to_fifo;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          full_viol = 0;
    logic [31:0] push_dat[$];
    int          push_cyc[$];

    axil_slave_to_fifo dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Push monitor samples on the falling edge, mid-cycle.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && fifo_wr_en === 1'b1) begin
            push_dat.push_back(fifo_din);
            push_cyc.push_back(cyc);
            if (fifo_full === 1'b1) full_viol = full_viol + 1;
        end
    end

    task automatic clear_log();
        push_dat.delete();
        push_cyc.delete();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_rready = 0; fifo_full = 0;
        s_axi_awaddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_araddr = 0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    // Drives one write; W leads AW by w_lead cycles; bready held low bready_wait cycles after bvalid.
    // viol counts cycles in the response phase where bvalid/bresp moved or the slave accepted or pushed.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int bready_wait,
                             output logic [1:0] resp, output int hs_cyc, output int b_cyc, output int viol);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int k = 0;
        viol = 0; hs_cyc = -1; b_cyc = -1; resp = 2'bxx;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        while (!(aw_done && w_done) && k < 60) begin
            s_axi_wvalid  = !w_done;
            s_axi_awvalid = !aw_done && (k >= w_lead);
            @(negedge aclk);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            if ((aw_done || aw_hs) && (w_done || w_hs)) hs_cyc = cyc;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            k++;
        end
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        if (!(aw_done && w_done)) begin
            checks++; errors++;
            $display("FAIL write_handshake_timeout addr=%h got aw=%0d w=%0d want both 1", addr, aw_done, w_done);
            return;
        end
        k = 0;
        do begin
            @(negedge aclk);
            k++;
        end while (s_axi_bvalid !== 1'b1 && k < 60);
        if (s_axi_bvalid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL bvalid_timeout addr=%h got bvalid=%b want 1", addr, s_axi_bvalid);
            return;
        end
        b_cyc = cyc;
        resp = s_axi_bresp;
        for (int i = 0; i < bready_wait; i++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== resp || s_axi_awready !== 1'b0 ||
                s_axi_wready !== 1'b0 || fifo_wr_en !== 1'b0) viol++;
        end
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    // Single status read; rready held low rready_wait cycles after rvalid; unst counts rvalid/rdata moves.
    task automatic axi_read(input int rready_wait, output logic [31:0] data, output int unst);
        bit hs;
        int k = 0;
        unst = 0; data = 32'hxxxx_xxxx;
        s_axi_arvalid = 1'b1;
        do begin
            @(negedge aclk);
            hs = s_axi_arvalid && s_axi_arready;
            @(posedge aclk); #1;
            k++;
        end while (!hs && k < 60);
        s_axi_arvalid = 1'b0;
        k = 0;
        while (s_axi_rvalid !== 1'b1 && k < 60) begin
            @(negedge aclk);
            k++;
        end
        if (s_axi_rvalid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL rvalid_timeout got rvalid=%b want 1", s_axi_rvalid);
            return;
        end
        data = s_axi_rdata;
        for (int i = 0; i < rready_wait; i++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== data) unst++;
        end
        s_axi_rready = 1'b1;
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_rready = 0; fifo_full = 0;
        s_axi_awaddr = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_araddr = 0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++; if (s_axi_awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", s_axi_awready); end
        checks++; if (s_axi_wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", s_axi_wready); end
        checks++; if (s_axi_bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", s_axi_bvalid); end
        checks++; if (s_axi_bresp !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", s_axi_bresp); end
        checks++; if (s_axi_arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", s_axi_arready); end
        checks++; if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", s_axi_rvalid); end
        checks++; if (s_axi_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", s_axi_rdata); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", fifo_wr_en); end
        checks++; if (fifo_din !== 32'h0) begin errors++; $display("FAIL rst_din got %h want 0", fifo_din); end
        @(posedge aclk); #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++; $display("FAIL post_rst_ready got %b want 111", {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_same_cycle();
        logic [1:0] resp; int hs, bc, viol;
        clear_log();
        axi_write(32'h1000_0000, 32'hABAB_ABAB, 4'hF, 0, 0, resp, hs, bc, viol);
        checks++; if (push_dat.size() != 2) begin errors++; $display("FAIL same_push_count got %0d want 2", push_dat.size()); end
        else begin
            checks++; if (push_dat[0] !== 32'hABAB_ABAB) begin errors++; $display("FAIL same_word0 got %h want abababab", push_dat[0]); end
            checks++; if (push_dat[1] !== 32'h1000_0000) begin errors++; $display("FAIL same_word1 got %h want 10000000", push_dat[1]); end
            checks++; if (push_cyc[0] != hs + 1 || push_cyc[1] != hs + 2) begin
                errors++; $display("FAIL same_push_timing got +%0d,+%0d want +1,+2", push_cyc[0] - hs, push_cyc[1] - hs);
            end
        end
        checks++; if (bc != hs + 3) begin errors++; $display("FAIL same_bvalid_latency got %0d want 3", bc - hs); end
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL same_bresp got %b want 00", resp); end
    endtask

    task automatic test_w_first_and_bready();
        logic [1:0] r1, r2; int hs, bc, v1, v2;
        clear_log();
        axi_write(32'h1000_0004, 32'hCAFE_F00D, 4'hF, 4, 0, r1, hs, bc, v1);
        axi_write(32'h1000_0001, 32'hABAB_ABAB, 4'hF, 0, 5, r2, hs, bc, v2);
        checks++; if (push_dat.size() != 4) begin errors++; $display("FAIL order_push_count got %0d want 4", push_dat.size()); end
        else begin
            checks++; if (push_dat[0] !== 32'hCAFE_F00D || push_dat[1] !== 32'h1000_0004) begin
                errors++; $display("FAIL order_pair0 got %h,%h want cafef00d,10000004", push_dat[0], push_dat[1]);
            end
            checks++; if (push_dat[2] !== 32'hABAB_ABAB || push_dat[3] !== 32'h1000_0001) begin
                errors++; $display("FAIL order_pair1 got %h,%h want abababab,10000001", push_dat[2], push_dat[3]);
            end
        end
        checks++; if (r1 !== 2'b00 || r2 !== 2'b00) begin errors++; $display("FAIL order_bresp got %b,%b want 00,00", r1, r2); end
        checks++; if (v2 != 0) begin errors++; $display("FAIL bready_hold_stable got %0d bad cycles want 0", v2); end
    endtask

    task automatic test_fifo_full();
        logic [1:0] resp; int hs, bc, viol, unst;
        logic [31:0] rd;
        clear_log();
        full_viol = 0;
        fork
            axi_write(32'h1000_0001, 32'h1234_5678, 4'hF, 0, 0, resp, hs, bc, viol);
            begin
                int g = 0;
                do begin @(negedge aclk); g++; end while (fifo_wr_en !== 1'b1 && g < 60);
                @(posedge aclk); #1 fifo_full = 1'b1;
                repeat (6) @(posedge aclk);
                #1 fifo_full = 1'b0;
            end
            begin
                int g = 0;
                do begin @(negedge aclk); g++; end while (fifo_full !== 1'b1 && g < 60);
                @(posedge aclk); #1;
                axi_read(0, rd, unst);
            end
        join
        checks++; if (push_dat.size() != 2) begin errors++; $display("FAIL full_push_count got %0d want 2", push_dat.size()); end
        else begin
            checks++; if (push_dat[0] !== 32'h1234_5678 || push_dat[1] !== 32'h1000_0001) begin
                errors++; $display("FAIL full_words got %h,%h want 12345678,10000001", push_dat[0], push_dat[1]);
            end
            checks++; if (push_cyc[1] - push_cyc[0] != 7) begin
                errors++; $display("FAIL full_stall_gap got %0d want 7", push_cyc[1] - push_cyc[0]);
            end
        end
        checks++; if (full_viol != 0) begin errors++; $display("FAIL full_wr_en_gate got %0d pushes while full want 0", full_viol); end
        checks++; if (rd !== 32'h0003_0003) begin errors++; $display("FAIL busy_status got %h want 00030003", rd); end
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL full_bresp got %b want 00", resp); end
    endtask

    task automatic test_bad_strb();
        logic [1:0] resp; int hs, bc, viol, unst;
        logic [31:0] rd;
        clear_log();
        axi_write(32'h1000_0000, 32'hDEAD_BEEF, 4'h3, 0, 0, resp, hs, bc, viol);
        checks++; if (push_dat.size() != 0) begin errors++; $display("FAIL strb_no_push got %0d pushes want 0", push_dat.size()); end
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL strb_bresp got %b want 10", resp); end
        axi_read(0, rd, unst);
        checks++; if (rd !== 32'h0004_0000) begin errors++; $display("FAIL strb_count got %h want 00040000", rd); end
    endtask

    task automatic test_status_read();
        logic [1:0] resp; int hs, bc, viol, unst;
        logic [31:0] rd;
        do_reset();
        clear_log();
        for (int i = 0; i < 3; i++)
            axi_write(32'h1000_0100 + 32'(i), 32'h0000_00A0 + 32'(i), 4'hF, i, 0, resp, hs, bc, viol);
        axi_read(2, rd, unst);
        checks++; if (rd[31:16] !== 16'd3) begin errors++; $display("FAIL status_count got %0d want 3", rd[31:16]); end
        checks++; if (rd[2:0] !== 3'b000) begin errors++; $display("FAIL status_flags got %b want 000", rd[2:0]); end
        checks++; if (unst != 0) begin errors++; $display("FAIL rvalid_hold got %0d bad cycles want 0", unst); end
        checks++; if (push_dat.size() != 6) begin errors++; $display("FAIL status_push_count got %0d want 6", push_dat.size()); end
    endtask

    task automatic test_window();
        logic [1:0] resp; int hs, bc, viol, unst;
        logic [31:0] rd;
        clear_log();
        axi_write(32'h2000_0000, 32'h55AA_55AA, 4'hF, 0, 0, resp, hs, bc, viol);
        axi_read(0, rd, unst);
`ifdef AXIL_FIFO_WIN_CHECK_EN
        checks++; if (resp !== 2'b10) begin errors++; $display("FAIL win_bresp got %b want 10", resp); end
        checks++; if (push_dat.size() != 0) begin errors++; $display("FAIL win_push_count got %0d want 0", push_dat.size()); end
        checks++; if (rd !== 32'h0003_0004) begin errors++; $display("FAIL win_status got %h want 00030004", rd); end
`else
        checks++; if (resp !== 2'b00) begin errors++; $display("FAIL win_bresp got %b want 00", resp); end
        checks++; if (push_dat.size() != 2) begin errors++; $display("FAIL win_push_count got %0d want 2", push_dat.size()); end
        checks++; if (rd !== 32'h0004_0000) begin errors++; $display("FAIL win_status got %h want 00040000", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first_and_bready();
        test_fifo_full();
        test_bad_strb();
        test_status_read();
        test_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
